// File: rtl/counter_monitor.sv
// counter_monitor: passive checker that locks onto an incrementing counter
// and reports sticky/pulsed mismatch status plus a saturating error count.
module counter_monitor #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned STEP        = 1,
  parameter int unsigned LOCK_CYCLES = 2,
  parameter int unsigned ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     counter_in,
  input  logic                 sample_en,
  input  logic                 clear,
  output logic                 locked,
  output logic                 error,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     first_bad,
  output logic [WIDTH-1:0]     first_exp
);

  // run must be able to hold LOCK_CYCLES itself
  localparam int unsigned     RunW    = $clog2(LOCK_CYCLES + 1);
  localparam logic [WIDTH-1:0] StepW  = WIDTH'(STEP);
  localparam logic [RunW-1:0]  LockRun = RunW'(LOCK_CYCLES);

  typedef enum logic [1:0] {StIdle, StAcquire, StTrack} state_e;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       expected_q, expected_d;
  logic [RunW-1:0]        run_q, run_d;
  logic                   error_q, error_d;
  logic                   err_pulse_q, err_pulse_d;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;
  logic [WIDTH-1:0]       first_bad_q, first_bad_d;
  logic [WIDTH-1:0]       first_exp_q, first_exp_d;

  logic [WIDTH-1:0]       next_exp;
  logic [RunW-1:0]        run_inc;
  logic                   match;

  assign next_exp = counter_in + StepW;  // truncation makes all-ones -> 0 legal
  assign run_inc  = run_q + 1'b1;
  assign match    = (counter_in == expected_q);

  // Next-state: acquisition/tracking FSM and error bookkeeping
  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    run_d       = run_q;
    error_d     = error_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    first_bad_d = first_bad_q;
    first_exp_d = first_exp_q;

    if (clear) begin
      state_d     = StIdle;
      expected_d  = '0;
      run_d       = '0;
      error_d     = 1'b0;
      err_count_d = '0;
      first_bad_d = '0;
      first_exp_d = '0;
    end else if (sample_en) begin
      expected_d = next_exp;
      case (state_q)
        StIdle: begin
          run_d   = '0;
          state_d = StAcquire;
        end
        StAcquire: begin
          if (match) begin
            run_d = run_inc;
            if (run_inc == LockRun) state_d = StTrack;
          end else begin
            run_d = '0;
          end
        end
        StTrack: begin
          if (!match) begin
            err_pulse_d = 1'b1;
            error_d     = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
            // Only the first mismatch since reset/clear is captured
            if (!error_q) begin
              first_bad_d = counter_in;
              first_exp_d = expected_q;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      expected_q  <= '0;
      run_q       <= '0;
      error_q     <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      first_bad_q <= '0;
      first_exp_q <= '0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      run_q       <= run_d;
      error_q     <= error_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      first_bad_q <= first_bad_d;
      first_exp_q <= first_exp_d;
    end
  end

  assign locked    = (state_q == StTrack);
  assign error     = error_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign first_bad = first_bad_q;
  assign first_exp = first_exp_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Scoreboard bench for counter_monitor: the driver pushes hand-computed
// expectations, a monitor pops and compares after each checked edge.
module tb_counter_monitor;

  logic       clk        = 1'b0;
  logic       rst        = 1'b0;
  logic [7:0] counter_in = 8'd0;
  logic       sample_en  = 1'b0;
  logic       clear      = 1'b0;

  logic        a_locked, a_error, a_err_pulse;
  logic [15:0] a_err_count;
  logic [7:0]  a_first_bad, a_first_exp;
  logic        b_locked, b_error, b_err_pulse;
  logic [3:0]  b_err_count;
  logic [7:0]  b_first_bad, b_first_exp;

  // Default-parameter instance
  counter_monitor dut_a (
    .clk        (clk),
    .rst        (rst),
    .counter_in (counter_in),
    .sample_en  (sample_en),
    .clear      (clear),
    .locked     (a_locked),
    .error      (a_error),
    .err_pulse  (a_err_pulse),
    .err_count  (a_err_count),
    .first_bad  (a_first_bad),
    .first_exp  (a_first_exp)
  );

  // STEP=3, 4-bit error counter instance
  counter_monitor #(
    .WIDTH       (8),
    .STEP        (3),
    .LOCK_CYCLES (2),
    .ERR_CNT_W   (4)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .counter_in (counter_in),
    .sample_en  (sample_en),
    .clear      (clear),
    .locked     (b_locked),
    .error      (b_error),
    .err_pulse  (b_err_pulse),
    .err_count  (b_err_count),
    .first_bad  (b_first_bad),
    .first_exp  (b_first_exp)
  );

  typedef struct packed {
    logic        l;
    logic        e;
    logic        p;
    logic [15:0] c;
    logic [7:0]  fb;
    logic [7:0]  fe;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  obs_t  act;
  bit    sel  = 1'b0;
  bit    chk  = 1'b0;
  bit    done = 1'b0;
  int    n_checks = 0;
  int    n_errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    if (sel) act = {b_locked, b_error, b_err_pulse, 12'd0, b_err_count, b_first_bad, b_first_exp};
    else     act = {a_locked, a_error, a_err_pulse, a_err_count, a_first_bad, a_first_exp};
  end

  // Monitor: compares after every checked clock edge or async reset edge
  initial begin : monitor
    obs_t  e;
    string nm;
    forever begin
      @(posedge clk or negedge rst or posedge done);
      if (done) begin
        if (exp_q.size() != 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL leftover: %0d expectations unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
      end else if (chk) begin
        #1;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL no_expectation: DUT output present but scoreboard empty");
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (act !== e) begin
            n_errors++;
            $display({"FAIL %s: got locked=%0b error=%0b pulse=%0b cnt=%0d bad=%0d exp=%0d; ",
                      "required locked=%0b error=%0b pulse=%0b cnt=%0d bad=%0d exp=%0d"},
                     nm, act.l, act.e, act.p, act.c, act.fb, act.fe,
                     e.l, e.e, e.p, e.c, e.fb, e.fe);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic push(input string nm, input logic l, input logic e, input logic p,
                      input int c, input logic [7:0] fb, input logic [7:0] fe);
    obs_t o;
    o.l  = l;
    o.e  = e;
    o.p  = p;
    o.c  = 16'(c);
    o.fb = fb;
    o.fe = fe;
    exp_q.push_back(o);
    name_q.push_back(nm);
  endtask

  task automatic drv(input string nm, input logic en, input logic clr, input logic [7:0] v,
                     input logic l, input logic e, input logic p, input int c,
                     input logic [7:0] fb, input logic [7:0] fe);
    @(negedge clk);
    sample_en  = en;
    clear      = clr;
    counter_in = v;
    chk        = 1'b1;
    push(nm, l, e, p, c, fb, fe);
  endtask

  // Sample with no error history expected
  task automatic ok(input string nm, input logic [7:0] v, input logic l);
    drv(nm, 1'b1, 1'b0, v, l, 1'b0, 1'b0, 0, 8'd0, 8'd0);
  endtask

  task automatic clr(input string nm);
    drv(nm, 1'b0, 1'b1, 8'(($urandom % 256)), 1'b0, 1'b0, 1'b0, 0, 8'd0, 8'd0);
  endtask

  initial begin : stimulus
    // Reset held with live stimulus
    for (int i = 0; i < 4; i++)
      drv("reset_hold", 1'b1, 1'b0, 8'(($urandom % 256)), 1'b0, 1'b0, 1'b0, 0, 8'd0, 8'd0);
    @(negedge clk);
    chk       = 1'b0;
    sample_en = 1'b0;
    rst       = 1'b1;

    // Clean wrap 250..255,0..5
    for (int i = 0; i < 12; i++) ok("wrap", 8'(250 + i), i >= 2);

    // TRACK skip
    clr("clr_skip");
    ok("skip_acq", 8'd7, 1'b0);
    ok("skip_acq", 8'd8, 1'b0);
    ok("skip_lock", 8'd9, 1'b1);
    ok("skip_10", 8'd10, 1'b1);
    ok("skip_11", 8'd11, 1'b1);
    drv("skip_13", 1'b1, 1'b0, 8'd13, 1'b1, 1'b1, 1'b1, 1, 8'd13, 8'd12);
    drv("skip_14", 1'b1, 1'b0, 8'd14, 1'b1, 1'b1, 1'b0, 1, 8'd13, 8'd12);
    drv("skip_15", 1'b1, 1'b0, 8'd15, 1'b1, 1'b1, 1'b0, 1, 8'd13, 8'd12);
    drv("skip_gap", 1'b0, 1'b0, 8'd15, 1'b1, 1'b1, 1'b0, 1, 8'd13, 8'd12);

    // clear beats a mismatching sample and returns to IDLE
    drv("clr_pri", 1'b1, 1'b1, 8'd99, 1'b0, 1'b0, 1'b0, 0, 8'd0, 8'd0);
    ok("clr_idle40", 8'd40, 1'b0);
    ok("clr_idle41", 8'd41, 1'b0);
    ok("clr_idle42", 8'd42, 1'b1);

    // ACQUIRE mismatch is silent
    clr("clr_acq");
    ok("acq_5", 8'd5, 1'b0);
    ok("acq_6", 8'd6, 1'b0);
    ok("acq_9", 8'd9, 1'b0);
    ok("acq_10", 8'd10, 1'b0);
    ok("acq_11", 8'd11, 1'b1);

    // Gaps with held counter
    for (int v = 12; v <= 16; v++) begin
      ok("gap_sample", 8'(v), 1'b1);
      drv("gap_hold", 1'b0, 1'b0, 8'(v), 1'b1, 1'b0, 1'b0, 0, 8'd0, 8'd0);
    end
    drv("trk_err", 1'b1, 1'b0, 8'd50, 1'b1, 1'b1, 1'b1, 1, 8'd50, 8'd17);

    // Async reset mid-TRACK, checked before the next clock edge
    @(negedge clk);
    sample_en = 1'b0;
    clear     = 1'b0;
    chk       = 1'b1;
    push("async_rst", 1'b0, 1'b0, 1'b0, 0, 8'd0, 8'd0);
    #2 rst = 1'b0;
    #1 chk = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    ok("post_rst", 8'd20, 1'b0);

    // Switch scoreboard to the STEP=3 instance once pending checks are done
    @(posedge clk);
    #2 sel = 1'b1;
    clr("b_clr");
    for (int k = 0; k <= 85; k++) ok("s3_wrap", 8'(3 * k), k >= 2);
    ok("s3_wrap_2", 8'd2, 1'b1);

    clr("b_clr_inj");
    ok("s3_0", 8'd0, 1'b0);
    ok("s3_3", 8'd3, 1'b0);
    ok("s3_6", 8'd6, 1'b1);
    drv("s3_inj8", 1'b1, 1'b0, 8'd8, 1'b1, 1'b1, 1'b1, 1, 8'd8, 8'd9);

    // Saturation of the 4-bit error count
    clr("b_clr_sat");
    ok("sat_0", 8'd0, 1'b0);
    ok("sat_3", 8'd3, 1'b0);
    ok("sat_6", 8'd6, 1'b1);
    for (int i = 0; i < 40; i++)
      drv("sat", 1'b1, 1'b0, (i % 2 == 1) ? 8'h80 : 8'h00, 1'b1, 1'b1, 1'b1,
          (i + 1 > 15) ? 15 : i + 1, 8'd0, 8'd9);
    drv("sat_hold", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 15, 8'd0, 8'd9);
    drv("b_clr_pri", 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 0, 8'd0, 8'd0);
    ok("b_idle", 8'd7, 1'b0);

    @(negedge clk);
    chk       = 1'b0;
    sample_en = 1'b0;
    @(posedge clk);
    #3 done = 1'b1;
  end

endmodule
